// File: rtl/nand_phy.sv
// Single-bank NAND PHY with a free-running address/read sequencer for board bring-up.
// Define NAND_PHY_CHIP1_EN to alternate bursts between chip 0 and chip 1.
module nand_phy #(
    parameter int INIT_WAIT   = 8,
    parameter int ADDR_CYCLES = 5,
    parameter int READ_CYCLES = 16,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       CLK_sysClkP,
    input  logic       CLK_sysClkN,
    input  logic       RST_N_sysRstn,
    inout  wire  [7:0] DQ,
    inout  wire        DQS,
    output logic       NAND_CLK,
    output logic       CLE,
    output logic       ALE,
    output logic       WRN,
    output logic       WPN,
    output logic [1:0] CEN
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [7:0] INIT_LAST = 8'(INIT_WAIT - 1);
    localparam logic [7:0] ADDR_LAST = 8'(ADDR_CYCLES - 1);
    localparam logic [7:0] READ_LAST = 8'(READ_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [7:0]  addr_base;
    logic [7:0]  dq_out;
    logic [7:0]  rd_last;
    logic [7:0]  rd_xor;
    logic [15:0] rd_count;
    logic [1:0]  next_cen;
    logic        unused;

`ifdef NAND_PHY_CHIP1_EN
    logic burst_odd;

    // Chip select for the burst that starts when GAP exits (toggle flips on that edge).
    always_comb begin
        next_cen = burst_odd ? 2'b10 : 2'b01;
    end

    always_ff @(posedge CLK_sysClkP) begin
        if (!RST_N_sysRstn) begin
            burst_odd <= 1'b0;
        end else if (state == ST_GAP && cnt == GAP_LAST) begin
            burst_odd <= ~burst_odd;
        end
    end
`else
    always_comb begin
        next_cen = 2'b10;
    end
`endif

    // The bus is owned by the PHY only while ALE is high.
    assign DQ  = ALE ? dq_out : 8'hzz;
    assign DQS = ALE ? 1'b0 : 1'bz;

    assign unused = ^{CLK_sysClkN, rd_last};

    always_ff @(posedge CLK_sysClkP) begin
        if (!RST_N_sysRstn) begin
            state     <= ST_INIT;
            cnt       <= 8'd0;
            addr_base <= 8'h00;
            dq_out    <= 8'h00;
            rd_last   <= 8'h00;
            rd_xor    <= 8'h00;
            rd_count  <= 16'h0000;
            NAND_CLK  <= 1'b0;
            CLE       <= 1'b0;
            ALE       <= 1'b0;
            WRN       <= 1'b1;
            WPN       <= 1'b0;
            CEN       <= 2'b11;
        end else begin
            NAND_CLK <= ~NAND_CLK;
            CLE      <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (cnt == INIT_LAST) begin
                        state  <= ST_ADDR;
                        cnt    <= 8'd0;
                        WPN    <= 1'b1;
                        ALE    <= 1'b1;
                        WRN    <= 1'b0;
                        CEN    <= 2'b10;
                        dq_out <= addr_base;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_ADDR: begin
                    if (cnt == ADDR_LAST) begin
                        state <= ST_READ;
                        cnt   <= 8'd0;
                        ALE   <= 1'b0;
                        WRN   <= 1'b1;
                    end else begin
                        cnt    <= cnt + 8'd1;
                        dq_out <= dq_out + 8'd1;
                    end
                end
                ST_READ: begin
                    rd_last  <= DQ;
                    rd_xor   <= rd_xor ^ DQ;
                    rd_count <= rd_count + 16'd1;
                    WRN      <= ~WRN;
                    if (cnt == READ_LAST) begin
                        state <= ST_GAP;
                        cnt   <= 8'd0;
                        CEN   <= 2'b11;
                        WRN   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state     <= ST_ADDR;
                        cnt       <= 8'd0;
                        addr_base <= addr_base + 8'd1;
                        dq_out    <= addr_base + 8'd1;
                        ALE       <= 1'b1;
                        WRN       <= 1'b0;
                        CEN       <= next_cen;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_phy.sv
// Randomized self-checking bench for nand_phy: bus model plus per-scenario tasks.
// Honours NAND_PHY_CHIP1_EN the same way the design does.
module tb_nand_phy;

    localparam int INIT_WAIT   = 8;
    localparam int ADDR_CYCLES = 5;
    localparam int READ_CYCLES = 16;
    localparam int GAP_CYCLES  = 2;

    logic       clk   = 1'b0;
    logic       clk_n;
    logic       rst_n = 1'b0;
    wire  [7:0] dq;
    wire        dqs;
    logic       nand_clk, cle, ale, wrn, wpn;
    logic [1:0] cen;

    logic [7:0] tb_dq = 8'h00;
    int checks = 0;
    int passes = 0;

    // Reference model of what the flash side has seen captured.
    logic [7:0]  m_last = 8'h00;
    logic [7:0]  m_xor  = 8'h00;
    logic [15:0] m_count = 16'h0000;
    int          read_left = 0;
    bit          pend_valid = 1'b0;
    logic [7:0]  pend_val = 8'h00;
    logic        prev_ale = 1'b0;

    always #5 clk = ~clk;
    assign clk_n = ~clk;

    // Flash model drives the bus whenever the PHY has ALE low.
    assign dq = (ale === 1'b0) ? tb_dq : 8'hzz;

    nand_phy dut (
        .CLK_sysClkP  (clk),
        .CLK_sysClkN  (clk_n),
        .RST_N_sysRstn(rst_n),
        .DQ           (dq),
        .DQS          (dqs),
        .NAND_CLK     (nand_clk),
        .CLE          (cle),
        .ALE          (ale),
        .WRN          (wrn),
        .WPN          (wpn),
        .CEN          (cen)
    );

    // The READ_CYCLES rising edges after ALE falls each capture the byte on the bus.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_last     = 8'h00;
            m_xor      = 8'h00;
            m_count    = 16'h0000;
            read_left  = 0;
            pend_valid = 1'b0;
        end else begin
            if (pend_valid) begin
                m_last     = pend_val;
                m_xor      = m_xor ^ pend_val;
                m_count    = m_count + 16'd1;
                pend_valid = 1'b0;
            end
            if (prev_ale === 1'b1 && ale === 1'b0) read_left = READ_CYCLES;
        end
        prev_ale = ale;
        tb_dq = 8'($urandom);
        if (read_left > 0) begin
            pend_val   = tb_dq;
            pend_valid = 1'b1;
            read_left  = read_left - 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [1:0] exp_cen(input int n);
`ifdef NAND_PHY_CHIP1_EN
        return (n % 2 == 1) ? 2'b01 : 2'b10;
`else
        return (n == n) ? 2'b10 : 2'b10;
`endif
    endfunction

    // Starts on the first ADDR cycle of burst n, ends on the first ADDR cycle of burst n+1.
    task automatic run_burst(input int n, input logic [7:0] base);
        logic [13:0] got, want;
        logic [1:0]  ce;
        ce = exp_cen(n);
        for (int k = 0; k < ADDR_CYCLES; k++) begin
            got  = {ale, cen, wrn, wpn, dqs, dq};
            want = {1'b1, ce, 1'b0, 1'b1, 1'b0, 8'(base + 8'(k))};
            checks++;
            if (got !== want) $display("[TB] FAIL addr_cycle burst=%0d k=%0d got=%h exp=%h", n, k, got, want);
            else passes++;
            tick();
        end
        for (int i = 0; i < READ_CYCLES; i++) begin
            checks++;
            if ({ale, cen, wrn} !== {1'b0, ce, ~i[0]})
                $display("[TB] FAIL read_ctrl burst=%0d i=%0d got=%b exp=%b", n, i, {ale, cen, wrn}, {1'b0, ce, ~i[0]});
            else passes++;
            checks++;
            if (dq !== tb_dq) $display("[TB] FAIL bus_contention burst=%0d i=%0d got=%h exp=%h", n, i, dq, tb_dq);
            else passes++;
            tick();
        end
        checks++;
        if ({dut.rd_count, dut.rd_xor, dut.rd_last} !== {m_count, m_xor, m_last})
            $display("[TB] FAIL read_capture burst=%0d got=%h/%h/%h exp=%h/%h/%h", n,
                     dut.rd_count, dut.rd_xor, dut.rd_last, m_count, m_xor, m_last);
        else passes++;
        for (int g = 0; g < GAP_CYCLES; g++) begin
            checks++;
            if ({ale, cen, wrn} !== 4'b0111)
                $display("[TB] FAIL gap_ctrl burst=%0d g=%0d got=%b exp=0111", n, g, {ale, cen, wrn});
            else passes++;
            tick();
        end
    endtask

    task automatic wait_init();
        for (int i = 1; i < INIT_WAIT; i++) begin
            tick();
            checks++;
            if ({ale, cen, wpn, nand_clk} !== {1'b0, 2'b11, 1'b0, i[0]})
                $display("[TB] FAIL init_wait i=%0d got=%b exp=%b", i, {ale, cen, wpn, nand_clk}, {1'b0, 2'b11, 1'b0, i[0]});
            else passes++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({ale, cen, wrn, wpn, cle, nand_clk} !== 7'b0111000)
                $display("[TB] FAIL reset_outputs i=%0d got=%b exp=0111000", i, {ale, cen, wrn, wpn, cle, nand_clk});
            else passes++;
            checks++;
            if (dq !== tb_dq) $display("[TB] FAIL reset_bus_release i=%0d got=%h exp=%h", i, dq, tb_dq);
            else passes++;
        end
        checks++;
        if ({dut.rd_count, dut.rd_xor, dut.rd_last} !== 32'h0)
            $display("[TB] FAIL reset_regs got=%h exp=0", {dut.rd_count, dut.rd_xor, dut.rd_last});
        else passes++;
        rst_n = 1'b1;
        wait_init();
    endtask

    task automatic test_first_burst();
        run_burst(0, 8'h00);
    endtask

    task automatic test_addr_wrap();
        for (int n = 1; n < 256; n++) run_burst(n, 8'(n));
        run_burst(256, 8'h00);
    endtask

    task automatic test_reset_mid_burst();
        tick();
        tick();
        checks++;
        if ({ale, dq} !== {1'b1, 8'h03}) $display("[TB] FAIL mid_addr got=%h exp=103", {ale, dq});
        else passes++;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ale, cen, wrn, wpn, nand_clk} !== 6'b011100)
            $display("[TB] FAIL mid_reset_outputs got=%b exp=011100", {ale, cen, wrn, wpn, nand_clk});
        else passes++;
        checks++;
        if (dq !== tb_dq) $display("[TB] FAIL mid_reset_bus got=%h exp=%h", dq, tb_dq);
        else passes++;
        checks++;
        if (dut.rd_count !== m_count) $display("[TB] FAIL mid_reset_count got=%h exp=%h", dut.rd_count, m_count);
        else passes++;
        rst_n = 1'b1;
        wait_init();
        run_burst(0, 8'h00);
    endtask

    task automatic test_back_to_back();
        for (int n = 1; n <= 3; n++) run_burst(n, 8'(n));
    endtask

    initial begin
        test_reset();
        test_first_burst();
        test_addr_wrap();
        test_reset_mid_burst();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
